// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline-stage register: valid/ready handshake with a 2-entry skid buffer,
// synchronous flush, and a saturating stall-cycle counter.
module pipe_stage_elastic #(
  parameter int DATA_W     = 32,
  parameter int CTRL_W     = 16,
  parameter int CLEAR_DATA = 1,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  // Encoding doubles as the occupancy count.
  typedef enum logic [1:0] {EMPTY = 2'd0, BUSY = 2'd1, FULL = 2'd2} state_t;

  state_t             state;
  logic [DATA_W-1:0]  main_data, skid_data;
  logic [CTRL_W-1:0]  main_ctrl, skid_ctrl;
  logic               accept, emit;

  // Handshake outputs decode only the state flops, so ready never depends on out_ready.
  assign out_valid = (state != EMPTY);
  assign in_ready  = (state != FULL);
  assign occupancy = state;
  assign out_data  = main_data;
  assign out_ctrl  = main_ctrl;
  assign accept    = in_valid & in_ready;
  assign emit      = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= EMPTY;
      main_data <= '0;
      main_ctrl <= '0;
      skid_data <= '0;
      skid_ctrl <= '0;
      stall_cnt <= '0;
    end else begin
      if (out_valid && !out_ready && stall_cnt != {CNT_W{1'b1}})
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (flush) begin
        state     <= EMPTY;
        main_ctrl <= '0;
        skid_ctrl <= '0;
        if (CLEAR_DATA != 0) begin
          main_data <= '0;
          skid_data <= '0;
        end
      end else begin
        case (state)
          EMPTY: if (accept) begin
            main_data <= in_data;
            main_ctrl <= in_ctrl;
            state     <= BUSY;
          end
          BUSY: begin
            if (accept && emit) begin
              main_data <= in_data;
              main_ctrl <= in_ctrl;
            end else if (emit) begin
              main_ctrl <= '0;
              state     <= EMPTY;
            end else if (accept) begin
              skid_data <= in_data;
              skid_ctrl <= in_ctrl;
              state     <= FULL;
            end
          end
          FULL: if (emit) begin
            main_data <= skid_data;
            main_ctrl <= skid_ctrl;
            skid_ctrl <= '0;
            state     <= BUSY;
          end
          default: state <= EMPTY;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pipe_stage_elastic;
  localparam int DATA_W = 32;
  localparam int CTRL_W = 16;
  localparam int CNT_W  = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CTRL_W-1:0] in_ctrl, out_ctrl;
  logic [1:0]        occupancy;
  logic [CNT_W-1:0]  stall_cnt;

  pipe_stage_elastic #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CLEAR_DATA(1), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl),
    .occupancy(occupancy), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference model: the stage is a FIFO of at most two beats, head is what is shown.
  logic [CTRL_W+DATA_W-1:0] q[$];
  int  mcnt = 0;
  bit  model_on = 1'b0;

  function automatic void model_step();
    int  n;
    bit  em, ac;
    if (rst) begin
      q.delete();
      mcnt     = 0;
      model_on = 1'b1;
      return;
    end
    n = q.size();
    if (n > 0 && !out_ready && mcnt < CNT_MAX) mcnt++;
    if (flush) begin
      q.delete();
      return;
    end
    em = (n > 0) && out_ready;
    ac = (n < 2) && in_valid;
    if (em) void'(q.pop_front());
    if (ac) q.push_back({in_ctrl, in_data});
  endfunction

  always @(posedge clk) model_step();

  always @(negedge clk) begin
    if (model_on) begin
      chk("out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("in_ready",  64'(in_ready),  64'(q.size() < 2));
      chk("occupancy", 64'(occupancy), 64'(q.size()));
      chk("stall_cnt", 64'(stall_cnt), 64'(mcnt));
      if (q.size() > 0) begin
        chk("out_data", 64'(out_data), 64'(q[0][DATA_W-1:0]));
        chk("out_ctrl", 64'(out_ctrl), 64'(q[0][CTRL_W+DATA_W-1:DATA_W]));
      end else begin
        chk("out_ctrl_idle", 64'(out_ctrl), 64'd0);
      end
    end
  end

  // Apply inputs for one cycle; returns at the following negedge.
  task automatic cyc(input bit r, input bit f, input bit iv, input logic [DATA_W-1:0] d, input bit ordy);
    rst = r; flush = f; in_valid = iv; in_data = d;
    in_ctrl = {8'hC0, d[7:0]};
    out_ready = ordy;
    @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ov"},  64'(out_valid), 64'd0);
    chk({tag, "_ir"},  64'(in_ready),  64'd1);
    chk({tag, "_occ"}, 64'(occupancy), 64'd0);
    chk({tag, "_ctl"}, 64'(out_ctrl),  64'd0);
    chk({tag, "_dat"}, 64'(out_data),  64'd0);
    chk({tag, "_cnt"}, 64'(stall_cnt), 64'd0);
  endtask

  initial begin
    // 1. reset
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    chk_reset_vals("rst");

    // 2. streaming 1..8
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1, DATA_W'(i), 1);
      chk("stream_dat", 64'(out_data), 64'(i));
      chk("stream_ctl", 64'(out_ctrl), 64'(16'hC000 | i));
      chk("stream_occ", 64'(occupancy), 64'd1);
    end
    cyc(0, 0, 0, 0, 1);
    chk("drain_ov", 64'(out_valid), 64'd0);

    // 3. back-pressure
    cyc(0, 0, 1, 32'h11, 0);
    chk("bp_a_dat", 64'(out_data), 64'h11);
    chk("bp_cnt0", 64'(stall_cnt), 64'd0);
    cyc(0, 0, 1, 32'h22, 0);
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_ir0", 64'(in_ready), 64'd0);
    chk("bp_cnt1", 64'(stall_cnt), 64'd1);
    cyc(0, 0, 0, 0, 0);
    chk("bp_cnt2", 64'(stall_cnt), 64'd2);
    chk("bp_head", 64'(out_data), 64'h11);
    cyc(0, 0, 0, 0, 1);
    chk("bp_b_dat", 64'(out_data), 64'h22);
    chk("bp_b_ov", 64'(out_valid), 64'd1);
    chk("bp_cnt_hold", 64'(stall_cnt), 64'd2);
    cyc(0, 0, 0, 0, 1);
    chk("bp_empty", 64'(out_valid), 64'd0);

    // 4. flush while FULL with C incoming
    cyc(0, 0, 1, 32'h33, 0);
    cyc(0, 0, 1, 32'h44, 0);
    chk("fl_full", 64'(occupancy), 64'd2);
    cyc(0, 1, 1, 32'hCC, 0);
    chk("fl_ov", 64'(out_valid), 64'd0);
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_ctl", 64'(out_ctrl), 64'd0);
    chk("fl_dat", 64'(out_data), 64'd0);
    chk("fl_cnt", 64'(stall_cnt), 64'd4);
    cyc(0, 0, 0, 0, 1);
    chk("fl_no_c", 64'(out_valid), 64'd0);

    // 5. saturation
    cyc(0, 0, 1, 32'h55, 0);
    for (int i = 0; i < 20; i++) cyc(0, 0, 0, 0, 0);
    chk("sat_cnt", 64'(stall_cnt), 64'd15);
    cyc(1, 0, 0, 0, 0);
    chk("sat_rst", 64'(stall_cnt), 64'd0);

    // 6. reset mid-stream while BUSY
    cyc(0, 0, 1, 32'h66, 1);
    chk("mid_busy", 64'(occupancy), 64'd1);
    cyc(1, 0, 1, 32'h77, 1);
    chk_reset_vals("mid");
    cyc(0, 0, 1, 32'h88, 1);
    chk("mid_new_ov", 64'(out_valid), 64'd1);
    chk("mid_new_dat", 64'(out_data), 64'h88);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      cyc($urandom_range(0, 99) == 0, $urandom_range(0, 24) == 0,
          $urandom_range(0, 2) != 0, $urandom, $urandom_range(0, 2) != 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
